// File: rtl/ddr_prog_dly_se_cfg_seq.sv
// Config sequencer for a single-ended programmable delay cell.
// Takes a target {gear, ena, ctrl} over a valid/ready handshake and walks the
// cell there glitch-free: ctrl moves one LSB at a time while enabled, gear only
// changes while disabled, and every config change is followed by a
// programmable settle wait.
//
// Ports:
//   i_clk, i_rst     clock; synchronous active-high reset
//   i_req_valid      request valid
//   o_req_ready      request ready (IDLE only)
//   i_req_ctrl       target delay code
//   i_req_gear       target gear
//   i_req_ena        target enable
//   i_settle_cyc     settle cycles after each change, latched at accept
//   o_busy           sequencer not idle
//   o_done           one-cycle pulse when the target is reached
//   o_prog_dly_cfg   registered {gear, ena, ctrl} to the delay cell
module ddr_prog_dly_se_cfg_seq #(
  parameter int unsigned CTRL_W   = 6,
  parameter int unsigned GEAR_W   = 2,
  parameter int unsigned SETTLE_W = 4,
  parameter int unsigned RST_GEAR = 0,
  parameter int unsigned PWIDTH   = CTRL_W + 1 + GEAR_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [CTRL_W-1:0]   i_req_ctrl,
  input  logic [GEAR_W-1:0]   i_req_gear,
  input  logic                i_req_ena,
  input  logic [SETTLE_W-1:0] i_settle_cyc,
  output logic                o_busy,
  output logic                o_done,
  output logic [PWIDTH-1:0]   o_prog_dly_cfg
);

  typedef enum logic [2:0] {
    StIdle,
    StDis,
    StLoad,
    StEna,
    StStep,
    StSettle,
    StDone
  } state_e;

  state_e state_q, state_d;
  state_e resume_q, resume_d;

  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic                ena_q, ena_d;
  logic [GEAR_W-1:0]   gear_q, gear_d;
  logic [CTRL_W-1:0]   tgt_ctrl_q, tgt_ctrl_d;
  logic [GEAR_W-1:0]   tgt_gear_q, tgt_gear_d;
  logic                tgt_ena_q, tgt_ena_d;
  logic [SETTLE_W-1:0] n_q, n_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  // An action state that changed the config raises adv; the common tail below
  // either moves straight to adv_to or parks in SETTLE for n_q cycles first.
  logic   adv;
  state_e adv_to;

  always_comb begin
    state_d    = state_q;
    resume_d   = resume_q;
    ctrl_d     = ctrl_q;
    ena_d      = ena_q;
    gear_d     = gear_q;
    tgt_ctrl_d = tgt_ctrl_q;
    tgt_gear_d = tgt_gear_q;
    tgt_ena_d  = tgt_ena_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    adv        = 1'b0;
    adv_to     = StIdle;

    unique case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          tgt_ctrl_d = i_req_ctrl;
          tgt_gear_d = i_req_gear;
          tgt_ena_d  = i_req_ena;
          n_d        = i_settle_cyc;
          if (!i_req_ena) begin
            state_d = StDis;
          end else if (!ena_q) begin
            state_d = StLoad;
          end else if (i_req_gear != gear_q) begin
            state_d = StDis;
          end else begin
            state_d = StStep;
          end
        end
      end
      StDis: begin
        ena_d  = 1'b0;
        adv    = 1'b1;
        adv_to = StLoad;
      end
      StLoad: begin
        // ena is already low here, so the gear switch is glitch-free.
        gear_d = tgt_gear_q;
        ctrl_d = tgt_ctrl_q;
        adv    = 1'b1;
        adv_to = tgt_ena_q ? StEna : StDone;
      end
      StEna: begin
        ena_d  = 1'b1;
        adv    = 1'b1;
        adv_to = StDone;
      end
      StStep: begin
        if (ctrl_q < tgt_ctrl_q) begin
          ctrl_d = ctrl_q + CTRL_W'(1);
          adv    = 1'b1;
          adv_to = StStep;
        end else if (ctrl_q > tgt_ctrl_q) begin
          ctrl_d = ctrl_q - CTRL_W'(1);
          adv    = 1'b1;
          adv_to = StStep;
        end else begin
          state_d = StDone;
        end
      end
      StSettle: begin
        if (cnt_q <= SETTLE_W'(1)) begin
          state_d = resume_q;
        end else begin
          cnt_d = cnt_q - SETTLE_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (adv) begin
      if (n_q == '0) begin
        state_d = adv_to;
      end else begin
        state_d  = StSettle;
        resume_d = adv_to;
        cnt_d    = n_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      resume_q   <= StIdle;
      ctrl_q     <= '0;
      ena_q      <= 1'b0;
      gear_q     <= GEAR_W'(RST_GEAR);
      tgt_ctrl_q <= '0;
      tgt_gear_q <= '0;
      tgt_ena_q  <= 1'b0;
      n_q        <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      resume_q   <= resume_d;
      ctrl_q     <= ctrl_d;
      ena_q      <= ena_d;
      gear_q     <= gear_d;
      tgt_ctrl_q <= tgt_ctrl_d;
      tgt_gear_q <= tgt_gear_d;
      tgt_ena_q  <= tgt_ena_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_req_ready    = (state_q == StIdle);
  assign o_busy         = (state_q != StIdle);
  assign o_done         = (state_q == StDone);
  assign o_prog_dly_cfg = {gear_q, ena_q, ctrl_q};

endmodule

// File: tb/tb_ddr_prog_dly_se_cfg_seq.sv
// Bench for ddr_prog_dly_se_cfg_seq: directed scenarios plus random requests,
// checked every cycle against a trace model built from the sequencing rules.
module tb_ddr_prog_dly_se_cfg_seq;
  localparam int CW = 6;
  localparam int GW = 2;
  localparam int SW = 4;
  localparam int PW = CW + 1 + GW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [CW-1:0] req_ctrl = '0;
  logic [GW-1:0] req_gear = '0;
  logic          req_ena = 1'b0;
  logic [SW-1:0] settle_cyc = '0;
  logic          busy;
  logic          done;
  logic [PW-1:0] cfg;

  always #5 clk = ~clk;

  ddr_prog_dly_se_cfg_seq dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_ctrl     (req_ctrl),
    .i_req_gear     (req_gear),
    .i_req_ena      (req_ena),
    .i_settle_cyc   (settle_cyc),
    .o_busy         (busy),
    .o_done         (done),
    .o_prog_dly_cfg (cfg)
  );

  int checks = 0;
  int failures = 0;

  // Expected per-cycle trace after an accept: cfg and done; busy throughout.
  logic [PW-1:0] exp_cfg_q[$];
  logic          exp_done_q[$];

  // Model of the cell config once the current request completes.
  logic [CW-1:0] m_ctrl = '0;
  logic          m_ena = 1'b0;
  logic [GW-1:0] m_gear = '0;
  logic [PW-1:0] cur;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // One config-changing action: one cycle at the old value, then the new value
  // held for n settle cycles.
  task automatic act(input logic [PW-1:0] nxt, input int n);
    exp_cfg_q.push_back(cur);
    exp_done_q.push_back(1'b0);
    cur = nxt;
    for (int i = 0; i < n; i++) begin
      exp_cfg_q.push_back(cur);
      exp_done_q.push_back(1'b0);
    end
  endtask

  task automatic build_trace(input logic [CW-1:0] tc, input logic [GW-1:0] tg,
                             input logic te, input int n);
    int c;
    cur = {m_gear, m_ena, m_ctrl};
    if (!te) begin
      act({m_gear, 1'b0, m_ctrl}, n);
      act({tg, 1'b0, tc}, n);
    end else if (m_ena && tg != m_gear) begin
      act({m_gear, 1'b0, m_ctrl}, n);
      act({tg, 1'b0, tc}, n);
      act({tg, 1'b1, tc}, n);
    end else if (!m_ena) begin
      act({tg, 1'b0, tc}, n);
      act({tg, 1'b1, tc}, n);
    end else begin
      c = int'(m_ctrl);
      while (c != int'(tc)) begin
        c = (c < int'(tc)) ? c + 1 : c - 1;
        act({m_gear, 1'b1, CW'(c)}, n);
      end
      exp_cfg_q.push_back(cur);  // step cycle that finds ctrl at target
      exp_done_q.push_back(1'b0);
    end
    exp_cfg_q.push_back(cur);
    exp_done_q.push_back(1'b1);
    m_ctrl = tc;
    m_gear = tg;
    m_ena  = te;
  endtask

  // Per-cycle compare against the model trace (or the idle state).
  always @(negedge clk) begin
    logic [PW-1:0] ecfg;
    logic edone, ebusy, eready;
    if (!rst) begin
      if (exp_cfg_q.size() > 0) begin
        ecfg = exp_cfg_q.pop_front();
        edone = exp_done_q.pop_front();
        ebusy = 1'b1;
        eready = 1'b0;
      end else begin
        ecfg = {m_gear, m_ena, m_ctrl};
        edone = 1'b0;
        ebusy = 1'b0;
        eready = 1'b1;
      end
      checks++;
      if (cfg !== ecfg || done !== edone || busy !== ebusy || req_ready !== eready) begin
        failures++;
        $display("FAIL cycle t=%0t cfg=%h/%h done=%b/%b busy=%b/%b ready=%b/%b (actual/expected)",
                 $time, cfg, ecfg, done, edone, busy, ebusy, req_ready, eready);
      end
    end
  end

  // Issue one request; returns the cycle (accept = 0) on which done was seen.
  task automatic do_req(input logic [CW-1:0] tc, input logic [GW-1:0] tg, input logic te,
                        input int n, input bit junk, output int done_cyc);
    int len;
    @(posedge clk);
    #1;
    req_ctrl = tc;
    req_gear = tg;
    req_ena = te;
    settle_cyc = SW'(n);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    build_trace(tc, tg, te, n);
    len = exp_cfg_q.size();
    done_cyc = -1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (done) begin
        done_cyc = c;
        break;
      end
      if (junk && c < len - 2) begin
        req_valid = 1'($urandom);
        req_ctrl = CW'($urandom);
        req_gear = GW'($urandom);
        req_ena = 1'($urandom);
        settle_cyc = SW'($urandom);
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    if (done_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout t=%0t actual=none expected=done", $time);
    end
  endtask

  initial begin
    int dc;
    logic [GW-1:0] g;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset state
    @(negedge clk);
    chk("rst_cfg", int'(cfg), 0);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    // 2: from disabled, load then enable with N=2
    do_req(6'd20, 2'd1, 1'b1, 2, 1'b0, dc);
    chk("t2_done_cyc", dc, 7);
    chk("t2_cfg", int'(cfg), int'({2'd1, 1'b1, 6'd20}));

    // 3: enabled step 10 -> 13 with N=2
    do_req(6'd10, 2'd1, 1'b1, 0, 1'b0, dc);
    chk("t3_setup_cyc", dc, 12);
    do_req(6'd13, 2'd1, 1'b1, 2, 1'b0, dc);
    chk("t3_done_cyc", dc, 11);
    chk("t3_cfg", int'(cfg), int'({2'd1, 1'b1, 6'd13}));

    // 4: gear change while enabled, N=0
    do_req(6'd5, 2'd2, 1'b1, 0, 1'b0, dc);
    chk("t4_done_cyc", dc, 4);
    chk("t4_cfg", int'(cfg), int'({2'd2, 1'b1, 6'd5}));

    // 5: downward step 7 -> 4 with valid asserted while busy
    do_req(6'd7, 2'd2, 1'b1, 0, 1'b0, dc);
    @(posedge clk);
    #1;
    req_ctrl = 6'd4;
    req_gear = 2'd2;
    req_ena = 1'b1;
    settle_cyc = '0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    build_trace(6'd4, 2'd2, 1'b1, 0);
    req_ctrl = 6'd60;  // stale valid stays high with a different target
    req_gear = 2'd0;
    dc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        dc = c;
        break;
      end
      if (c >= 3) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    chk("t5_done_cyc", dc, 5);
    chk("t5_cfg", int'(cfg), int'({2'd2, 1'b1, 6'd4}));

    // 6: reset during SETTLE aborts without done
    do_req(6'd0, 2'd0, 1'b0, 0, 1'b0, dc);
    @(posedge clk);
    #1;
    req_ctrl = 6'd30;
    req_gear = 2'd3;
    req_ena = 1'b1;
    settle_cyc = 4'd15;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    build_trace(6'd30, 2'd3, 1'b1, 15);
    repeat (4) @(negedge clk);
    chk("t6_busy_pre", int'(busy), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_cfg_q.delete();
    exp_done_q.delete();
    m_ctrl = '0;
    m_ena = 1'b0;
    m_gear = '0;
    @(negedge clk);
    chk("t6_done_in_rst", int'(done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_cfg", int'(cfg), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(done), 0);

    // Random requests with junk valid while busy
    for (int i = 0; i < 40; i++) begin
      g = ($urandom_range(2) == 0) ? GW'($urandom) : m_gear;
      do_req(CW'($urandom), g, ($urandom_range(3) != 0), $urandom_range(3), 1'b1, dc);
      repeat ($urandom_range(2)) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
